// File: rtl/mem_stream_reader.sv
// mem_stream_reader: streams a run of sequential RAM words as a ready/valid
// stream. Reads are issued only when the output FIFO is certain to have room
// for them. The fixed RAM read latency is hidden behind a small shift register
// that tracks in-flight reads.

// Watches the output buffer bookkeeping for overflow and over-commitment.
module mem_stream_reader_chk #(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] fifo_count,
  input logic [CNT_W:0]   occupancy
);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W:0]   OCC_LIMIT = (CNT_W + 1)'(BUF_DEPTH);

  // A push into a full buffer, or more reserved slots than the buffer holds, is a design bug.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (fifo_count == CNT_FULL)))
        else $error("mem_stream_reader: output FIFO overflow");
      assert (occupancy <= OCC_LIMIT)
        else $error("mem_stream_reader: buffer over-committed");
    end
  end
endmodule

module mem_stream_reader #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 14,
  parameter int READ_LATENCY = 2,
  parameter int BUF_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_start_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [PTR_W-1:0]    PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [OCC_W-1:0]    OCC_LIMIT = OCC_W'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] REM_ONE   = (ADDR_WIDTH + 1)'(1);

  generate
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
      $error("mem_stream_reader: READ_LATENCY must be 1 or 2");
    end
    if (BUF_DEPTH < READ_LATENCY + 2) begin : g_bad_depth
      $error("mem_stream_reader: BUF_DEPTH must be at least READ_LATENCY+2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Command progress
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;

  // In-flight read tracker: one valid bit and one last-word tag per latency stage
  logic [READ_LATENCY-1:0] track_vld_q, track_vld_d;
  logic [READ_LATENCY-1:0] track_last_q, track_last_d;

  // Output FIFO
  logic [DATA_WIDTH-1:0] fifo_data_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  fifo_last_q;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;

  // Registered status outputs
  logic cmd_ready_q, cmd_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Per-cycle decisions
  logic             accept_s;
  logic             issue_s;
  logic             push_s;
  logic             push_last_s;
  logic             pop_s;
  logic             drain_done_s;
  logic [CNT_W-1:0] inflight_s;
  logic [OCC_W-1:0] occupancy_s;

  // Handshakes, buffer occupancy and the issue decision for this cycle.
  always_comb begin
    accept_s    = cmd_valid && cmd_ready_q;
    push_s      = track_vld_q[READ_LATENCY-1];
    push_last_s = track_last_q[READ_LATENCY-1];
    pop_s       = (fifo_count_q != '0) && out_ready;
    inflight_s  = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_s = inflight_s + CNT_W'(track_vld_q[i]);
    end
    // Reads already in flight reserve their FIFO slot; pops this cycle are not credited.
    occupancy_s = OCC_W'(fifo_count_q) + OCC_W'(inflight_s);
    issue_s     = (state_q == S_READ) && (remaining_q != '0) && (occupancy_s < OCC_LIMIT);
    // The final beat leaves on this edge once nothing else is buffered or pending.
    drain_done_s = (inflight_s == '0) &&
                   ((fifo_count_q == '0) || ((fifo_count_q == CNT_ONE) && pop_s));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = (cmd_len == '0) ? S_DONE : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (issue_s && (remaining_q == REM_ONE)) begin
          state_d = S_DRAIN;
        end else if (remaining_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if (drain_done_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs, computed from the next state so they are registered with it.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = ((state_q == S_DRAIN) && drain_done_s) ||
                  (accept_s && (cmd_len == '0));
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Address and remaining-count update: load on accept, advance on each issue.
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    if (accept_s) begin
      addr_d      = cmd_start_addr;
      remaining_d = cmd_len;
    end else if (issue_s) begin
      addr_d      = addr_q + ADDR_ONE;
      remaining_d = remaining_q - REM_ONE;
    end else begin
      addr_d      = addr_q;
      remaining_d = remaining_q;
    end
  end

  // Tracker shift: stage 0 records this cycle's issue, later stages age it.
  always_comb begin
    track_vld_d     = track_vld_q;
    track_last_d    = track_last_q;
    track_vld_d[0]  = issue_s;
    track_last_d[0] = issue_s && (remaining_q == REM_ONE);
    for (int i = 1; i < READ_LATENCY; i++) begin
      track_vld_d[i]  = track_vld_q[i-1];
      track_last_d[i] = track_last_q[i-1];
    end
  end

  // FIFO pointer and count update.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : (wr_ptr_q + PTR_ONE);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : (rd_ptr_q + PTR_ONE);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fifo_count_d = fifo_count_q + CNT_ONE;
      2'b01:   fifo_count_d = fifo_count_q - CNT_ONE;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // Datapath registers: address, count, tracker and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      track_vld_q  <= '0;
      track_last_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      track_vld_q  <= track_vld_d;
      track_last_q <= track_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // FIFO storage: capture RAM data when the tracker's output stage is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
      end
      fifo_last_q <= '0;
    end else if (push_s) begin
      fifo_data_q[wr_ptr_q] <= mem_rd_data;
      fifo_last_q[wr_ptr_q] <= push_last_s;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign out_valid = (fifo_count_q != '0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q] && (fifo_count_q != '0);

  mem_stream_reader_chk #(
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .pop        (pop_s),
    .fifo_count (fifo_count_q),
    .occupancy  (occupancy_s)
  );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: directed scenarios followed by
// randomized commands, RAM contents and backpressure, all compared against a
// word-list reference model of the RAM.
module tb_mem_stream_reader;
  localparam int AW = 6;
  localparam int DW = 14;
  localparam int RL = 2;
  localparam int BD = 4;
  localparam int MEM_WORDS = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_start_addr;
  logic [AW:0]   cmd_len;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;   // 0: held by the sequence, 1: random, 2: toggling

  logic [DW-1:0] ram [MEM_WORDS];
  logic [DW-1:0] rd_pipe;
  logic [DW-1:0] got_data [$];
  logic          got_last [$];

  mem_stream_reader #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (RL),
    .BUF_DEPTH    (BD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_start_addr (cmd_start_addr),
    .cmd_len        (cmd_len),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Two-cycle RAM: address sampled at one edge, data visible after the next.
  always @(posedge clk) begin
    rd_pipe     <= ram[mem_addr];
    mem_rd_data <= rd_pipe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed hang expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: log any beat handshaked at this edge and check that a
  // stalled beat stays put.
  task automatic cycle();
    logic          pend;
    logic [DW-1:0] hd;
    logic          hl;
    pend = (out_valid === 1'b1) && (out_ready === 1'b0);
    hd   = out_data;
    hl   = out_last;
    if ((out_valid === 1'b1) && (out_ready === 1'b1)) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
    @(posedge clk);
    #1;
    if (pend) begin
      chk("hold_valid", out_valid, 32'd1);
      chk("hold_data", out_data, hd);
      chk("hold_last", out_last, hl);
    end
    if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 2) out_ready = ~out_ready;
  endtask

  task automatic send_cmd(input int s, input int l);
    int n;
    n = 0;
    while ((cmd_ready !== 1'b1) && (n < 300)) begin
      cycle();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 32'd1);
    cmd_valid      = 1'b1;
    cmd_start_addr = s[AW-1:0];
    cmd_len        = l[AW:0];
    cycle();
    cmd_valid      = 1'b0;
    cmd_start_addr = AW'($urandom);
    cmd_len        = (AW + 1)'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((done !== 1'b1) && (n < budget)) begin
      cycle();
      n++;
    end
    chk(tag, done, 32'd1);
  endtask

  // Reference: word k of a command is ram[(start+k) mod 64], last on k == len-1.
  task automatic check_stream(input string tag, input int start, input int len);
    chk({tag, "_count"}, got_data.size(), len);
    for (int k = 0; (k < len) && (k < got_data.size()); k++) begin
      chk({tag, "_data"}, got_data[k], ram[(start + k) % MEM_WORDS]);
      chk({tag, "_last"}, got_last[k], (k == len - 1));
    end
    got_data.delete();
    got_last.delete();
  endtask

  initial begin
    int n;
    int vcount;
    int s;
    int l;
    for (int i = 0; i < MEM_WORDS; i++) ram[i] = DW'(14'h100 + i);
    rst_n          = 1'b0;
    cmd_valid      = 1'b0;
    cmd_start_addr = '0;
    cmd_len        = '0;
    out_ready      = 1'b1;

    // Reset values
    #2;
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", out_last, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_cmd_ready", cmd_ready, 32'd1);

    // 1: basic burst, latency and done timing
    send_cmd(5, 4);
    chk("t1_busy", busy, 32'd1);
    chk("t1_cmd_ready_low", cmd_ready, 32'd0);
    chk("t1_valid_e0", out_valid, 32'd0);
    cycle();
    chk("t1_valid_e1", out_valid, 32'd0);
    cycle();
    chk("t1_valid_e2", out_valid, 32'd0);
    cycle();
    for (int k = 0; k < 4; k++) begin
      chk("t1_beat_valid", out_valid, 32'd1);
      chk("t1_beat_data", out_data, 32'h105 + k);
      chk("t1_beat_last", out_last, (k == 3));
      cycle();
    end
    chk("t1_done", done, 32'd1);
    chk("t1_idle_busy", busy, 32'd0);
    chk("t1_idle_ready", cmd_ready, 32'd1);
    chk("t1_idle_valid", out_valid, 32'd0);
    check_stream("t1", 5, 4);
    cycle();
    chk("t1_done_pulse", done, 32'd0);

    // 2: address wrap
    send_cmd(62, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_mem_addr", mem_addr, (62 + i) % MEM_WORDS);
      cycle();
    end
    wait_done("t2_done", 100);
    check_stream("t2", 62, 4);

    // 3: backpressure stall then toggling ready
    send_cmd(0, 16);
    n = 0;
    while ((got_data.size() < 1) && (n < 20)) begin
      cycle();
      n++;
    end
    chk("t3_first_beat", got_data.size(), 32'd1);
    out_ready = 1'b0;
    repeat (10) cycle();
    chk("t3_stall_addr", mem_addr, 32'd5);
    chk("t3_stall_valid", out_valid, 32'd1);
    chk("t3_stall_data", out_data, 32'h101);
    cycle();
    chk("t3_stall_addr_hold", mem_addr, 32'd5);
    rdy_mode = 2;
    wait_done("t3_done", 400);
    rdy_mode = 0;
    out_ready = 1'b1;
    check_stream("t3", 0, 16);

    // 4: zero-length command
    send_cmd(7, 0);
    chk("t4_busy", busy, 32'd1);
    chk("t4_done", done, 32'd1);
    vcount = (out_valid === 1'b1) ? 1 : 0;
    cycle();
    chk("t4_busy_after", busy, 32'd0);
    chk("t4_done_after", done, 32'd0);
    chk("t4_ready_after", cmd_ready, 32'd1);
    repeat (3) begin
      if (out_valid === 1'b1) vcount++;
      cycle();
    end
    chk("t4_no_valid", vcount, 32'd0);
    check_stream("t4", 7, 0);

    // 5: full memory then a back-to-back command offered in the done cycle
    send_cmd(0, 64);
    wait_done("t5_done", 300);
    chk("t5_ready_in_done", cmd_ready, 32'd1);
    check_stream("t5", 0, 64);
    send_cmd(3, 2);
    chk("t5_b2b_accept", busy, 32'd1);
    wait_done("t5_b2b_done", 100);
    check_stream("t5_b2b", 3, 2);

    // 6: reset in the middle of a burst
    send_cmd(20, 10);
    n = 0;
    while ((got_data.size() < 3) && (n < 30)) begin
      cycle();
      n++;
    end
    chk("t6_three_beats", got_data.size(), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mem_addr", mem_addr, 32'd0);
    chk("t6_rst_valid", out_valid, 32'd0);
    chk("t6_rst_data", out_data, 32'd0);
    chk("t6_rst_last", out_last, 32'd0);
    chk("t6_rst_busy", busy, 32'd0);
    chk("t6_rst_done", done, 32'd0);
    got_data.delete();
    got_last.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_ready_after", cmd_ready, 32'd1);
    send_cmd(10, 2);
    wait_done("t6_done", 100);
    check_stream("t6", 10, 2);

    // Randomized commands, contents and backpressure
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < MEM_WORDS; i++) ram[i] = DW'($urandom);
      rdy_mode = 1;
      s = $urandom_range(0, MEM_WORDS - 1);
      l = (r == 5) ? 64 : ((r == 2) ? 0 : $urandom_range(1, 24));
      send_cmd(s, l);
      wait_done("rand_done", 1500);
      check_stream("rand", s, l);
    end
    rdy_mode = 0;
    out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
